// File: rtl/i2s_tx_stereo24_if.sv
// Handshake and serial-output bundle for the 24-bit stereo I2S transmitter.
// The DUT connects through the slave modport; the upstream source and the bench use master.
interface i2s_tx_stereo24_if;
  logic               strobe;
  logic               in_valid;
  logic signed [23:0] in_left;
  logic signed [23:0] in_right;
  logic               in_ready;
  logic               lrclk;
  logic               data;
  logic               underrun;
  logic        [7:0]  underrun_count;

  modport master (
    output strobe, in_valid, in_left, in_right,
    input  in_ready, lrclk, data, underrun, underrun_count
  );

  modport slave (
    input  strobe, in_valid, in_left, in_right,
    output in_ready, lrclk, data, underrun, underrun_count
  );
endinterface

// File: rtl/i2s_tx_stereo24.sv
// 24-bit stereo I2S transmitter: 64 BCLK frames, MSB first, lrclk leading each channel by one BCLK.
// Define I2S_TX_UNDERRUN_MUTE_EN to clear the hold registers on underrun (default: repeat last sample).
module i2s_tx_stereo24 (
  input  logic               clk,
  input  logic               resetn,
  i2s_tx_stereo24_if.slave   bus
);

  localparam int DATA_W = 24;

  logic        [5:0]        c_q, c_d;
  logic signed [DATA_W-1:0] hold_l_q, hold_l_d;
  logic signed [DATA_W-1:0] hold_r_q, hold_r_d;
  logic                     lrclk_q, lrclk_d;
  logic                     data_q, data_d;
  logic                     und_q, und_d;
  logic        [7:0]        ucnt_q, ucnt_d;
  logic                     req, xfer, miss;

  // Word select is high for the last left bit slot through the penultimate right slot.
  function automatic logic lr_sel(input logic [5:0] c);
    return (c >= 6'd31) && (c <= 6'd62);
  endfunction

  function automatic logic serial_bit(input logic [5:0] c,
                                      input logic signed [DATA_W-1:0] l,
                                      input logic signed [DATA_W-1:0] r);
    logic [4:0]        pos;
    logic [DATA_W-1:0] w;
    pos = c[4:0];
    w   = c[5] ? r : l;
    w   = w << pos;
    return (pos < 5'd24) ? w[DATA_W-1] : 1'b0;
  endfunction

  assign req  = bus.strobe && (c_q == 6'd62);
  assign xfer = req && bus.in_valid;
  assign miss = req && !bus.in_valid;

  always_comb begin
    c_d      = c_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    lrclk_d  = lrclk_q;
    data_d   = data_q;
    und_d    = miss;
    ucnt_d   = ucnt_q;
    if (bus.strobe) begin
      c_d     = c_q + 6'd1;
      lrclk_d = lr_sel(c_d);
      // Hold only changes at c'=63, where the data slot is padding, so the old hold is safe here.
      data_d  = serial_bit(c_d, hold_l_q, hold_r_q);
    end
    if (xfer) begin
      hold_l_d = bus.in_left;
      hold_r_d = bus.in_right;
    end else if (miss) begin
      if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      hold_l_d = '0;
      hold_r_d = '0;
`else
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_q      <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      lrclk_q  <= 1'b0;
      data_q   <= 1'b0;
      und_q    <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      c_q      <= c_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      lrclk_q  <= lrclk_d;
      data_q   <= data_d;
      und_q    <= und_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign bus.in_ready       = req;
  assign bus.lrclk          = lrclk_q;
  assign bus.data           = data_q;
  assign bus.underrun       = und_q;
  assign bus.underrun_count = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_stereo24.sv
`timescale 1ns/1ps
module tb_i2s_tx_stereo24;

  logic clk;
  logic resetn;
  i2s_tx_stereo24_if bus ();

  i2s_tx_stereo24 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_c;
  int          m_uc;
  logic [23:0] m_hl, m_hr;
  logic [63:0] cap;

  task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_lr(input int c);
    return (c >= 31) && (c <= 62);
  endfunction

  function automatic logic exp_data(input int c, input logic [23:0] hl, input logic [23:0] hr);
    logic [23:0] w;
    int pos;
    pos = c % 32;
    w   = (c < 32) ? hl : hr;
    if (pos < 24) return w[23 - pos];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_c  = 0;
    m_uc = 0;
    m_hl = '0;
    m_hr = '0;
  endtask

  task automatic step(input bit v, input logic [23:0] l, input logic [23:0] r, input int gap);
    bit xf, ms;
    logic e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_left  = l;
    bus.in_right = r;
    bus.strobe   = 1'b1;
    #1;
    e = (m_c == 62);
    check("in_ready", bus.in_ready === e, bus.in_ready, e);
    xf = (m_c == 62) && v;
    ms = (m_c == 62) && !v;
    @(posedge clk);
    #1;
    bus.strobe = 1'b0;
    m_c = (m_c + 1) % 64;
    if (xf) begin
      m_hl = l;
      m_hr = r;
    end else if (ms) begin
      if (m_uc < 255) m_uc++;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      m_hl = '0;
      m_hr = '0;
`endif
    end
    cap = {cap[62:0], bus.data};
    check("lrclk", bus.lrclk === exp_lr(m_c), bus.lrclk, exp_lr(m_c));
    check("data", bus.data === exp_data(m_c, m_hl, m_hr), bus.data, exp_data(m_c, m_hl, m_hr));
    check("underrun", bus.underrun === ms, bus.underrun, ms);
    check("underrun_count", bus.underrun_count === 8'(m_uc), bus.underrun_count, 8'(m_uc));
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_left  = 24'($urandom);
      bus.in_right = 24'($urandom);
      #1;
      check("idle_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
      check("idle_underrun", bus.underrun === 1'b0, bus.underrun, 1'b0);
      check("idle_lrclk", bus.lrclk === exp_lr(m_c), bus.lrclk, exp_lr(m_c));
      check("idle_data", bus.data === exp_data(m_c, m_hl, m_hr), bus.data, exp_data(m_c, m_hl, m_hr));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.strobe   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    cap          = '0;
    model_reset();

    resetn = 1'b0;
    #12;
    bus.strobe   = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
    check("rst_lrclk", bus.lrclk === 1'b0, bus.lrclk, 1'b0);
    check("rst_data", bus.data === 1'b0, bus.data, 1'b0);
    check("rst_underrun", bus.underrun === 1'b0, bus.underrun, 1'b0);
    check("rst_count", bus.underrun_count === 8'h00, bus.underrun_count, 8'h00);
    bus.strobe = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 63; i++) step(1'b1, 24'hA5A5A5, 24'h5A5A5A, 25);
    for (int i = 0; i < 64; i++) step(1'b1, 24'hA5A5A5, 24'h5A5A5A, 25);
    check("frame_pattern", cap === 64'hA5A5A5_00_5A5A5A_00, cap, 64'hA5A5A5_00_5A5A5A_00);

    for (int i = 0; i < 256; i++)
      step(1'b1, 24'($urandom), 24'($urandom), int'($urandom_range(1, 4)));

    for (int i = 0; i < 128; i++) step(1'b0, 24'($urandom), 24'($urandom), 1);
    check("two_underruns", bus.underrun_count === 8'd2, bus.underrun_count, 8'd2);
    for (int i = 0; i < 64; i++) step(1'b1, 24'($urandom), 24'($urandom), 1);

    for (int i = 0; i < 300 * 64; i++) step(1'b0, 24'($urandom), 24'($urandom), 1);
    check("count_saturated", bus.underrun_count === 8'd255, bus.underrun_count, 8'd255);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.in_left  = 24'($urandom);
      bus.in_right = 24'($urandom);
      #1;
      if (i % 100 == 0) check("hold_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
      if (i % 100 == 0) begin
        check("hold_lrclk", bus.lrclk === exp_lr(m_c), bus.lrclk, exp_lr(m_c));
        check("hold_data", bus.data === exp_data(m_c, m_hl, m_hr), bus.data, exp_data(m_c, m_hl, m_hr));
      end
    end
    for (int i = 0; i < 64; i++) step(1'b1, 24'($urandom), 24'($urandom), 2);

    while (m_c != 40) step(1'b1, 24'($urandom), 24'($urandom), 1);
    @(negedge clk);
    bus.strobe = 1'b1;
    resetn     = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready === 1'b0, bus.in_ready, 1'b0);
    check("midrst_lrclk", bus.lrclk === 1'b0, bus.lrclk, 1'b0);
    check("midrst_data", bus.data === 1'b0, bus.data, 1'b0);
    check("midrst_count", bus.underrun_count === 8'h00, bus.underrun_count, 8'h00);
    bus.strobe = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 140; i++)
      step(1'b1, 24'($urandom), 24'($urandom), int'($urandom_range(1, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
